demux1x2_buf: RTL and testbench
===============================

DEMUX1X2_BUF -- requirements
Module: demux1x2_buf

Interface
REQ-001 SHALL have parameter LARGURA, default 32, data word width in bits.
REQ-002 SHALL have parameter PROFUNDIDADE, default 2, entries per output buffer (power of two, >= 2).
REQ-003 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port entrada  input  LARGURA  incoming data word.
REQ-006 SHALL have port entrada_valida  input  1  entrada and seletor hold a valid word.
REQ-007 SHALL have port seletor  input  1  destination select: 0 routes to saida0, 1 routes to saida1.
REQ-008 SHALL have port entrada_pronta  output  1  block accepts the word this cycle.
REQ-009 SHALL have port saida0 / saida1  output  LARGURA  head word of buffer 0 / 1.
REQ-010 SHALL have port saida0_valida / saida1_valida  output  1  buffer 0 / 1 non-empty.
REQ-011 SHALL have port saida0_pronta / saida1_pronta  input  1  consumer 0 / 1 takes the head word.
REQ-012 SHALL have port contador0 / contador1  output  8  words delivered on output 0 / 1, modulo 256.

Function
REQ-013 SHALL transfer an input word when entrada_valida=1 and entrada_pronta=1 at a rising edge (push).
REQ-014 SHALL drive entrada_pronta = 1 iff the buffer selected by the current seletor holds fewer than PROFUNDIDADE words; no dependency on saidaX_pronta.
REQ-015 SHALL write a pushed word into buffer 0 when seletor=0, buffer 1 when seletor=1, never both.
REQ-016 SHALL transfer an output word on port X when saidaX_valida=1 and saidaX_pronta=1 at a rising edge (pop).
REQ-017 SHALL drive saidaX_valida = 1 iff buffer X occupancy > 0; saidaX shows the oldest word (FIFO order per buffer).
REQ-018 SHALL present a pushed word on its saidaX one cycle after the push edge when buffer X was empty (latency 1, no combinational input-to-output path).
REQ-019 SHALL, on simultaneous push and pop of the same buffer, keep occupancy unchanged and preserve FIFO order.
REQ-020 SHALL, when buffer X is full, hold entrada_pronta=0 for seletor=X even if saidaX_pronta=1 that cycle.
REQ-021 SHALL let a full buffer stall only its own destination; words for the other destination are still accepted.
REQ-022 SHALL keep saidaX stable while saidaX_valida=1 and saidaX_pronta=0.
REQ-023 SHALL implement read/write pointers wrapping modulo PROFUNDIDADE and occupancy counters of width log2(PROFUNDIDADE)+1.
REQ-024 SHALL increment contadorX by 1 on each pop of port X, wrapping 255 -> 0.
REQ-025 SHALL ignore entrada and seletor when entrada_valida=0; pops proceed regardless.
REQ-026 SHALL treat saidaX_pronta asserted while saidaX_valida=0 as no-op (no pointer, counter change).

Reset
REQ-027 SHALL, while reset_n=0, immediately force both occupancies, pointers and contador0/1 to 0, saida0_valida=saida1_valida=0.
REQ-028 SHALL drive saida0/saida1 = 0 during reset and whenever the corresponding buffer is empty.
REQ-029 SHALL discard all buffered words on reset asserted mid-operation; no pop or push counted in the reset cycle.
REQ-030 SHALL assert entrada_pronta=1 in the first cycle after reset_n rises.

Verification
REQ-031 SHALL cover: push 0xAAAA0001 seletor=0, saida0_pronta=0 -> next cycle saida0_valida=1, saida0=0xAAAA0001, saida1_valida=0.
REQ-032 SHALL cover: 3 pushes seletor=1 (0x11,0x22,0x33), saida1_pronta=0 -> first two accepted, entrada_pronta=0 for the third; then seletor=0 push 0x44 accepted.
REQ-033 SHALL cover: buffer 0 holding one word, push and pop port 0 same edge -> occupancy stays 1, saida0 shows the new word next cycle.
REQ-034 SHALL cover: 257 pops on port 1 with saida1_pronta held 1 -> contador1 = 1 after the last pop.
REQ-035 SHALL cover: both buffers full, reset_n pulsed low between edges -> all valids 0, contadores 0, entrada_pronta=1 after release.
REQ-036 SHALL cover: random valid/pronta/seletor for 10k cycles -> per-port output sequence equals scoreboard of pushed words for that seletor, no loss or duplication.

Source files
------------

// File: rtl/demux1x2_buf.sv
// rtl/demux1x2_buf.sv - 1-to-2 stream demultiplexer with a small FIFO per output
//
// Each accepted input word goes to one of two independent FIFOs, chosen by seletor.
// Each output port shows the oldest word of its FIFO.
//
// Parameters
//   LARGURA       data word width in bits
//   PROFUNDIDADE  entries per output FIFO (power of two, >= 2)
//
// Ports
//   clock                        single clock, rising edge
//   reset_n                      asynchronous, active-low reset
//   entrada / entrada_valida     incoming word and its valid flag
//   seletor                      destination: 0 -> saida0, 1 -> saida1
//   entrada_pronta               the FIFO picked by seletor has free space
//   saidaX / saidaX_valida       head word of FIFO X / FIFO X is not empty
//   saidaX_pronta                consumer X takes the head word
//   contadorX                    words delivered on port X, modulo 256
module demux1x2_buf #(
  parameter int LARGURA      = 32,
  parameter int PROFUNDIDADE = 2
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [LARGURA-1:0] entrada,
  input  logic               entrada_valida,
  input  logic               seletor,
  output logic               entrada_pronta,
  output logic [LARGURA-1:0] saida0,
  output logic [LARGURA-1:0] saida1,
  output logic               saida0_valida,
  output logic               saida1_valida,
  input  logic               saida0_pronta,
  input  logic               saida1_pronta,
  output logic [7:0]         contador0,
  output logic [7:0]         contador1
);

  localparam int PW = $clog2(PROFUNDIDADE);
  localparam int CW = PW + 1;

  // Index 0 belongs to output 0 and index 1 to output 1.
  logic [LARGURA-1:0] mem_q      [2][PROFUNDIDADE];
  logic [PW-1:0]      wr_ptr_q   [2];
  logic [PW-1:0]      wr_ptr_d   [2];
  logic [PW-1:0]      rd_ptr_q   [2];
  logic [PW-1:0]      rd_ptr_d   [2];
  logic [CW-1:0]      count_q    [2];
  logic [CW-1:0]      count_d    [2];
  logic [7:0]         contador_q [2];
  logic [7:0]         contador_d [2];

  logic [1:0] sel_hot;
  logic [1:0] full;
  logic [1:0] nonempty;
  logic [1:0] pronta;
  logic [1:0] push;
  logic [1:0] pop;
  logic       accept;

  assign sel_hot = {seletor, ~seletor};
  assign pronta  = {saida1_pronta, saida0_pronta};

  always_comb begin
    for (int x = 0; x < 2; x++) begin
      full[x]     = (count_q[x] == CW'(PROFUNDIDADE));
      nonempty[x] = (count_q[x] != '0);
    end
  end

  // Readiness looks only at occupancy before the edge. A pop on the same edge does
  // not free a slot early, so a full FIFO always refuses its own destination.
  assign entrada_pronta = seletor ? ~full[1] : ~full[0];
  assign accept         = entrada_valida & entrada_pronta;
  assign push           = {2{accept}} & sel_hot;
  assign pop            = nonempty & pronta;

  always_comb begin
    for (int x = 0; x < 2; x++) begin
      // The pointers are exactly PW bits wide, so they wrap modulo PROFUNDIDADE
      // without any extra logic.
      wr_ptr_d[x]   = wr_ptr_q[x] + PW'(push[x]);
      rd_ptr_d[x]   = rd_ptr_q[x] + PW'(pop[x]);
      count_d[x]    = count_q[x] + CW'(push[x]) - CW'(pop[x]);
      contador_d[x] = contador_q[x] + 8'(pop[x]);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int x = 0; x < 2; x++) begin
        wr_ptr_q[x]   <= '0;
        rd_ptr_q[x]   <= '0;
        count_q[x]    <= '0;
        contador_q[x] <= '0;
      end
    end else begin
      for (int x = 0; x < 2; x++) begin
        wr_ptr_q[x]   <= wr_ptr_d[x];
        rd_ptr_q[x]   <= rd_ptr_d[x];
        count_q[x]    <= count_d[x];
        contador_q[x] <= contador_d[x];
      end
    end
  end

  // The storage has no reset. An entry is only visible while the occupancy counter
  // covers it, and the outputs are forced to zero when a FIFO is empty.
  always_ff @(posedge clock) begin
    for (int x = 0; x < 2; x++) begin
      if (push[x]) begin
        mem_q[x][wr_ptr_q[x]] <= entrada;
      end
    end
  end

  assign saida0_valida = nonempty[0];
  assign saida1_valida = nonempty[1];
  assign saida0        = nonempty[0] ? mem_q[0][rd_ptr_q[0]] : '0;
  assign saida1        = nonempty[1] ? mem_q[1][rd_ptr_q[1]] : '0;
  assign contador0     = contador_q[0];
  assign contador1     = contador_q[1];

endmodule

// File: tb/tb_demux1x2_buf.sv
// tb/tb_demux1x2_buf.sv - queue-scoreboard testbench for demux1x2_buf
module tb_demux1x2_buf;

  localparam int W = 32;
  localparam int D = 2;

  logic         clock = 1'b0;
  logic         reset_n;
  logic [W-1:0] entrada;
  logic         entrada_valida;
  logic         seletor;
  logic         entrada_pronta;
  logic [W-1:0] saida0;
  logic [W-1:0] saida1;
  logic         saida0_valida;
  logic         saida1_valida;
  logic         saida0_pronta;
  logic         saida1_pronta;
  logic [7:0]   contador0;
  logic [7:0]   contador1;

  demux1x2_buf #(.LARGURA(W), .PROFUNDIDADE(D)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .entrada       (entrada),
    .entrada_valida(entrada_valida),
    .seletor       (seletor),
    .entrada_pronta(entrada_pronta),
    .saida0        (saida0),
    .saida1        (saida1),
    .saida0_valida (saida0_valida),
    .saida1_valida (saida1_valida),
    .saida0_pronta (saida0_pronta),
    .saida1_pronta (saida1_pronta),
    .contador0     (contador0),
    .contador1     (contador1)
  );

  always #10 clock = ~clock;

  // Reference model: one queue per destination plus a delivered-word count per port.
  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];
  int pops0 = 0;
  int pops1 = 0;
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs are driven on the falling edge. Readiness is checked 1 time unit later,
  // the monitor runs 3 units later, and the push is recorded 5 units later, all
  // before the next rising edge.
  task automatic cycle(input bit v, input bit s, input logic [W-1:0] d, input bit r0, input bit r1);
    bit ok;
    @(negedge clock);
    entrada_valida = v;
    seletor        = s;
    entrada        = d;
    saida0_pronta  = r0;
    saida1_pronta  = r1;
    #1;
    ok = ((s ? q1.size() : q0.size()) < D);
    check("entrada_pronta", entrada_pronta, ok);
    #4;
    if (v && ok) begin
      if (s) q1.push_back(d);
      else   q0.push_back(d);
    end
  endtask

  initial begin
    forever begin
      @(negedge clock);
      #3;
      if (reset_n) begin
        check("saida0_valida", saida0_valida, q0.size() > 0);
        check("contador0", contador0, pops0 % 256);
        if (q0.size() > 0) begin
          check("saida0", saida0, q0[0]);
          if (saida0_pronta) begin
            void'(q0.pop_front());
            pops0++;
          end
        end else begin
          check("saida0_empty", saida0, '0);
        end
        check("saida1_valida", saida1_valida, q1.size() > 0);
        check("contador1", contador1, pops1 % 256);
        if (q1.size() > 0) begin
          check("saida1", saida1, q1[0]);
          if (saida1_pronta) begin
            void'(q1.pop_front());
            pops1++;
          end
        end else begin
          check("saida1_empty", saida1, '0);
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_v0"}, saida0_valida, 0);
    check({tag, "_v1"}, saida1_valida, 0);
    check({tag, "_s0"}, saida0, '0);
    check({tag, "_s1"}, saida1, '0);
    check({tag, "_c0"}, contador0, 0);
    check({tag, "_c1"}, contador1, 0);
  endtask

  // Reset is pulsed low entirely between two rising edges.
  task automatic pulse_reset();
    @(negedge clock);
    entrada_valida = 1'b0;
    saida0_pronta  = 1'b0;
    saida1_pronta  = 1'b0;
    #5 reset_n = 1'b0;
    #1 check_reset_outputs("rst_mid");
    q0.delete();
    q1.delete();
    pops0 = 0;
    pops1 = 0;
    #1 reset_n = 1'b1;
    seletor = 1'b0;
    #1 check("pronta_after_rst_sel0", entrada_pronta, 1);
    seletor = 1'b1;
    #1 check("pronta_after_rst_sel1", entrada_pronta, 1);
  endtask

  initial begin
    reset_n        = 1'b0;
    entrada        = '0;
    entrada_valida = 1'b0;
    seletor        = 1'b0;
    saida0_pronta  = 1'b0;
    saida1_pronta  = 1'b0;
    repeat (2) @(negedge clock);
    #1 check_reset_outputs("rst_init");
    reset_n = 1'b1;

    // One word for output 0 appears one cycle after its push.
    cycle(1, 0, 32'hAAAA0001, 0, 0);
    cycle(0, 0, '0, 0, 0);
    check("d1_v0", saida0_valida, 1);
    check("d1_s0", saida0, 32'hAAAA0001);
    check("d1_v1", saida1_valida, 0);

    // Push and pop of output 0 on the same edge keeps one word, the new one.
    cycle(1, 0, 32'hBBBB0002, 1, 0);
    cycle(0, 0, '0, 0, 0);
    check("d3_v0", saida0_valida, 1);
    check("d3_s0", saida0, 32'hBBBB0002);
    cycle(0, 0, '0, 1, 0);

    // A full output 1 stalls only its own destination.
    cycle(1, 1, 32'h11, 0, 0);
    cycle(1, 1, 32'h22, 0, 0);
    cycle(1, 1, 32'h33, 0, 0);
    check("d2_full_stall", entrada_pronta, 0);
    cycle(1, 0, 32'h44, 0, 0);
    check("d2_other_ok", entrada_pronta, 1);
    // A pop on the same edge does not free the full FIFO for this cycle.
    cycle(1, 1, 32'h55, 0, 1);
    check("d2_full_pop", entrada_pronta, 0);

    // Fill both FIFOs, then reset between edges.
    cycle(1, 1, 32'h66, 0, 0);
    cycle(1, 0, 32'h77, 0, 0);
    cycle(0, 0, '0, 0, 0);
    check("d5_full_v0", saida0_valida, 1);
    check("d5_full_v1", saida1_valida, 1);
    pulse_reset();

    // 257 pops on output 1, so the counter wraps to 1.
    for (int i = 0; i < 257; i++) cycle(1, 1, W'(32'h1000 + i), 0, 1);
    cycle(0, 0, '0, 0, 1);
    cycle(0, 0, '0, 0, 0);
    check("d4_contador1", contador1, 8'd1);

    // Random traffic.
    for (int i = 0; i < 10000; i++) begin
      cycle(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 1)), W'($urandom),
            bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 2) != 0));
    end

    // Drain the FIFOs. Every pushed word must have been delivered.
    repeat (6) cycle(0, 0, '0, 1, 1);
    check("drain_q0", W'(q0.size()), '0);
    check("drain_q1", W'(q1.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
